// File: rtl/dff_mem_fifo.sv
// Flip-flop memory tile: random-access RAM (mode 0) or synchronous FIFO (mode 1).
// Define DFF_MEM_PARITY_EN to store and check an even-parity bit per word.
module dff_mem_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              par_inj,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_err,
  output logic              rd_err,
  output logic              par_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef DFF_MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              mode_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic              mode_sw_c;
  logic              push_ok_c;
  logic              pop_ok_c;
  logic              mem_we_c;
  logic              mem_re_c;
  logic              wr_rej_c;
  logic              rd_rej_c;
  logic [ADDR_W-1:0] wr_idx_c;
  logic [ADDR_W-1:0] rd_idx_c;
  logic [MEM_W-1:0]  wr_word_c;
  logic [MEM_W-1:0]  rd_word_c;
  logic [CNT_W-1:0]  count_nxt_c;
  logic              par_bad_c;

  // Request decode; acceptance uses pre-edge status, so no bypass paths exist.
  always_comb begin
    mode_sw_c   = (mode != mode_q);
    push_ok_c   = mode_q && !mode_sw_c && wr_en && !full;
    pop_ok_c    = mode_q && !mode_sw_c && rd_en && !empty;
    wr_rej_c    = mode_q && !mode_sw_c && wr_en && full;
    rd_rej_c    = mode_q && !mode_sw_c && rd_en && empty;
    mem_we_c    = ena && !mode_sw_c && (mode_q ? push_ok_c : wr_en);
    mem_re_c    = ena && !mode_sw_c && (mode_q ? pop_ok_c : rd_en);
    wr_idx_c    = mode_q ? wr_ptr : addr;
    rd_idx_c    = mode_q ? rd_ptr : addr;
    count_nxt_c = count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    rd_word_c   = mem[rd_idx_c];
  end

`ifdef DFF_MEM_PARITY_EN
  // Stored bit makes the word even parity unless par_inj flips it.
  assign wr_word_c = {(^wr_data) ^ par_inj, wr_data};
  assign par_bad_c = ^rd_word_c;
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign wr_word_c      = wr_data;
  assign par_bad_c      = 1'b0;
`endif

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[wr_idx_c] <= wr_word_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
      par_err  <= 1'b0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      mode_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (!ena) begin
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      rd_valid <= mem_re_c;
      wr_err   <= wr_rej_c;
      rd_err   <= rd_rej_c;
      par_err  <= mem_re_c && par_bad_c;
      if (mem_re_c) rd_data <= rd_word_c[DATA_W-1:0];
      if (mode_sw_c) begin
        mode_q <= mode;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        empty  <= 1'b1;
        full   <= 1'b0;
      end else if (mode_q) begin
        if (push_ok_c) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop_ok_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
        count <= count_nxt_c;
        empty <= (count_nxt_c == '0);
        full  <= (count_nxt_c == CNT_W'(DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_dff_mem_fifo.sv
// Self-checking bench for dff_mem_fifo against a queue/array reference model.
module tb_dff_mem_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              mode;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wr_data;
  logic              par_inj;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              wr_err;
  logic              rd_err;
  logic              par_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_mode;
  logic [7:0]  m_ram [DEPTH];
  bit          m_known [DEPTH];
  logic [7:0]  m_q [$];
  logic [7:0]  e_data;
  bit          e_data_ok;
  bit          e_valid, e_werr, e_rerr;

  dff_mem_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .addr(addr),
    .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data), .par_inj(par_inj),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .wr_err(wr_err), .rd_err(rd_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 1'b0;
    m_q.delete();
    e_data = 8'h00;
    e_data_ok = 1'b1;
    e_valid = 1'b0;
    e_werr = 1'b0;
    e_rerr = 1'b0;
  endtask

  // One clock of stimulus; the model is advanced from the spec-level rules.
  task automatic apply(input bit en, input bit md, input bit we, input bit re,
                       input logic [3:0] a, input logic [7:0] d);
    bit push_ok, pop_ok;
    ena = en; mode = md; wr_en = we; rd_en = re; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    e_valid = 1'b0; e_werr = 1'b0; e_rerr = 1'b0;
    if (en) begin
      if (md != m_mode) begin
        m_mode = md;
        m_q.delete();
      end else if (!m_mode) begin
        if (re) begin
          e_valid = 1'b1;
          e_data_ok = m_known[a];
          e_data = m_ram[a];
        end
        if (we) begin
          m_ram[a] = d;
          m_known[a] = 1'b1;
        end
      end else begin
        push_ok = we && (m_q.size() < DEPTH);
        pop_ok  = re && (m_q.size() > 0);
        e_werr = we && !push_ok;
        e_rerr = re && !pop_ok;
        if (pop_ok) begin
          e_valid = 1'b1;
          e_data = m_q.pop_front();
          e_data_ok = 1'b1;
        end
        if (push_ok) begin
          m_q.push_back(d);
          foreach (m_known[i]) m_known[i] = 1'b0;
        end
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; mode = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wr_data = '0; par_inj = 1'b0;
    foreach (m_known[i]) m_known[i] = 1'b0;
    model_reset();
    #12;
    n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %0h exp 0", rd_data); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %0b exp 0", rd_valid); end
    n_vec++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_status: empty %0b full %0b exp 1 0", empty, full); end
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_vec++; if ({wr_err, rd_err, par_err} !== 3'b000) begin n_err++; $display("FAIL reset_errs: got %03b exp 000", {wr_err, rd_err, par_err}); end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 0, 0, 0, 4'd0, 8'h00);
    n_vec++; if (rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL idle: valid %0b count %0d empty %0b exp 0 0 1", rd_valid, count, empty); end
  endtask

  task automatic test_ram_basic();
    apply(1, 0, 1, 0, 4'd3, 8'hA5);
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL ram_wr_valid: got %0b exp 0", rd_valid); end
    apply(1, 0, 0, 1, 4'd3, 8'h00);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin n_err++; $display("FAIL ram_rd: valid %0b data %0h exp 1 a5", rd_valid, rd_data); end
    apply(1, 0, 0, 0, 4'd0, 8'h00);
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin n_err++; $display("FAIL ram_hold: valid %0b data %0h exp 0 a5", rd_valid, rd_data); end
  endtask

  task automatic test_ram_rbw();
    apply(1, 0, 1, 1, 4'd3, 8'h5A);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin n_err++; $display("FAIL ram_rbw_old: valid %0b data %0h exp 1 a5", rd_valid, rd_data); end
    apply(1, 0, 0, 1, 4'd3, 8'h00);
    n_vec++; if (rd_data !== 8'h5A) begin n_err++; $display("FAIL ram_rbw_new: got %0h exp 5a", rd_data); end
  endtask

  task automatic test_fifo_fill_drain();
    apply(1, 1, 0, 0, 4'd0, 8'h00);
    n_vec++; if (count !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL fifo_enter: count %0d empty %0b exp 0 1", count, empty); end
    for (int i = 1; i <= 16; i++) begin
      apply(1, 1, 1, 0, 4'($urandom), 8'(i));
      n_vec++; if (count !== 5'(i)) begin n_err++; $display("FAIL fill_count: got %0d exp %0d", count, i); end
    end
    n_vec++; if (full !== 1'b1 || empty !== 1'b0) begin n_err++; $display("FAIL fill_full: full %0b empty %0b exp 1 0", full, empty); end
    apply(1, 1, 1, 0, 4'd0, 8'hEE);
    n_vec++; if (wr_err !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin n_err++; $display("FAIL overflow: wr_err %0b count %0d full %0b exp 1 16 1", wr_err, count, full); end
    apply(1, 1, 0, 0, 4'd0, 8'h00);
    n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL wr_err_pulse: got %0b exp 0", wr_err); end
    for (int i = 1; i <= 16; i++) begin
      apply(1, 1, 0, 1, 4'd0, 8'h00);
      n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'(i) || count !== 5'(16 - i)) begin n_err++; $display("FAIL drain: valid %0b data %0h count %0d exp 1 %0h %0d", rd_valid, rd_data, count, i, 16 - i); end
    end
    n_vec++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL drain_empty: empty %0b full %0b exp 1 0", empty, full); end
    apply(1, 1, 0, 1, 4'd0, 8'h00);
    n_vec++; if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h10) begin n_err++; $display("FAIL underflow: rd_err %0b valid %0b data %0h exp 1 0 10", rd_err, rd_valid, rd_data); end
  endtask

  task automatic test_fifo_simul();
    logic [7:0] first;
    first = 8'($urandom);
    apply(1, 1, 1, 0, 4'd0, first);
    for (int i = 0; i < 4; i++) apply(1, 1, 1, 0, 4'd0, 8'($urandom));
    apply(1, 1, 1, 1, 4'd0, 8'($urandom));
    n_vec++; if (count !== 5'd5 || rd_valid !== 1'b1 || rd_data !== first) begin n_err++; $display("FAIL simul_mid: count %0d valid %0b data %0h exp 5 1 %0h", count, rd_valid, rd_data, first); end
    while (m_q.size() > 0) apply(1, 1, 0, 1, 4'd0, 8'h00);
    apply(1, 1, 1, 1, 4'd0, 8'h99);
    n_vec++; if (count !== 5'd1 || rd_err !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty: count %0d rd_err %0b valid %0b exp 1 1 0", count, rd_err, rd_valid); end
    for (int i = 0; i < 15; i++) apply(1, 1, 1, 0, 4'd0, 8'($urandom));
    apply(1, 1, 1, 1, 4'd0, 8'h77);
    n_vec++; if (count !== 5'd15 || wr_err !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'h99) begin n_err++; $display("FAIL simul_full: count %0d wr_err %0b valid %0b data %0h exp 15 1 1 99", count, wr_err, rd_valid, rd_data); end
  endtask

  task automatic test_mode_switch();
    while (m_q.size() > 0) apply(1, 1, 0, 1, 4'd0, 8'h00);
    for (int i = 0; i < 3; i++) apply(1, 1, 1, 0, 4'd0, 8'($urandom));
    n_vec++; if (count !== 5'd3) begin n_err++; $display("FAIL sw_pre: count %0d exp 3", count); end
    apply(1, 0, 1, 1, 4'd3, 8'hFF);
    n_vec++; if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || {wr_err, rd_err} !== 2'b00) begin n_err++; $display("FAIL sw_to_ram: count %0d empty %0b valid %0b errs %02b exp 0 1 0 00", count, empty, rd_valid, {wr_err, rd_err}); end
    apply(1, 1, 1, 1, 4'd0, 8'h77);
    n_vec++; if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_err !== 1'b0) begin n_err++; $display("FAIL sw_to_fifo: count %0d empty %0b valid %0b rd_err %0b exp 0 1 0 0", count, empty, rd_valid, rd_err); end
    apply(1, 1, 0, 0, 4'd0, 8'h00);
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL sw_ignored_push: count %0d exp 0", count); end
  endtask

  task automatic test_ena();
    apply(1, 1, 1, 0, 4'd0, 8'h11);
    apply(1, 1, 1, 0, 4'd0, 8'h22);
    apply(0, 1, 1, 1, 4'd0, 8'h33);
    n_vec++; if (count !== 5'd2 || rd_valid !== 1'b0 || rd_data !== e_data) begin n_err++; $display("FAIL ena_freeze: count %0d valid %0b data %0h exp 2 0 %0h", count, rd_valid, rd_data, e_data); end
    apply(0, 0, 1, 1, 4'd0, 8'h44);
    n_vec++; if (count !== 5'd2 || empty !== 1'b0) begin n_err++; $display("FAIL ena_no_switch: count %0d empty %0b exp 2 0", count, empty); end
    apply(1, 1, 0, 1, 4'd0, 8'h00);
    n_vec++; if (rd_data !== 8'h11 || count !== 5'd1) begin n_err++; $display("FAIL ena_resume: data %0h count %0d exp 11 1", rd_data, count); end
  endtask

  task automatic test_random();
    bit md;
    for (int n = 0; n < 400; n++) begin
      md = m_mode;
      if ($urandom_range(99) < 4) md = !md;
      apply($urandom_range(99) < 90, md, $urandom_range(1), $urandom_range(1),
            4'($urandom_range(7)), 8'($urandom));
      n_vec++; if (rd_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid @%0d: got %0b exp %0b", n, rd_valid, e_valid); end
      n_vec++; if (wr_err !== e_werr || rd_err !== e_rerr) begin n_err++; $display("FAIL rnd_errs @%0d: got %0b%0b exp %0b%0b", n, wr_err, rd_err, e_werr, e_rerr); end
      n_vec++; if (count !== 5'(m_q.size()) || full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)) begin n_err++; $display("FAIL rnd_status @%0d: count %0d full %0b empty %0b exp count %0d", n, count, full, empty, m_q.size()); end
      if (e_data_ok) begin
        n_vec++; if (rd_data !== e_data) begin n_err++; $display("FAIL rnd_data @%0d: got %0h exp %0h", n, rd_data, e_data); end
        n_vec++; if (par_err !== 1'b0) begin n_err++; $display("FAIL rnd_par @%0d: got %0b exp 0", n, par_err); end
      end
    end
  endtask

  task automatic test_parity();
    bit exp_pe;
`ifdef DFF_MEM_PARITY_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    apply(1, 0, 0, 0, 4'd0, 8'h00);
    par_inj = 1'b1;
    apply(1, 0, 1, 0, 4'd9, 8'h3C);
    par_inj = 1'b0;
    apply(1, 0, 0, 1, 4'd9, 8'h00);
    n_vec++; if (rd_data !== 8'h3C || rd_valid !== 1'b1 || par_err !== exp_pe) begin n_err++; $display("FAIL par_inj: data %0h valid %0b par_err %0b exp 3c 1 %0b", rd_data, rd_valid, par_err, exp_pe); end
    apply(1, 0, 1, 0, 4'd9, 8'h3C);
    apply(1, 0, 0, 1, 4'd9, 8'h00);
    n_vec++; if (rd_data !== 8'h3C || par_err !== 1'b0) begin n_err++; $display("FAIL par_clean: data %0h par_err %0b exp 3c 0", rd_data, par_err); end
  endtask

  task automatic test_async_reset();
    apply(1, 1, 0, 0, 4'd0, 8'h00);
    apply(1, 1, 1, 0, 4'd0, 8'hC3);
    apply(1, 1, 1, 0, 4'd0, 8'h3C);
    apply(1, 1, 0, 1, 4'd0, 8'h00);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin n_err++; $display("FAIL ar_pre: valid %0b data %0h exp 1 c3", rd_valid, rd_data); end
    ena = 1'b1; mode = 1'b1; rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL async_reset: valid %0b data %0h count %0d empty %0b full %0b exp 0 0 0 1 0", rd_valid, rd_data, count, empty, full); end
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_ram_rbw();
    test_fifo_fill_drain();
    test_fifo_simul();
    test_mode_switch();
    test_ena();
    test_random();
    test_parity();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dff_mem_fifo.md
# dff_mem_fifo

Parametrised flip-flop memory with two run-time modes: random-access RAM, and synchronous FIFO with full/empty/count status and error pulses. This block is the next-generation DFF memory tile. It generalises the fixed 16×8 register RAM to configurable width and depth, and adds registered read-valid signalling, FIFO sequencing and optional per-word parity. It sits between the pad-level input decode and any consumer needing small local storage.

## Interface
- `DATA_W`, 8, word width in bits (≥1)
- `ADDR_W`, 4, address width; `DEPTH = 2**ADDR_W` words (derived)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  clock enable; low freezes all state
- `mode`  in  1  0 = RAM, 1 = FIFO
- `addr`  in  ADDR_W  RAM-mode address; ignored in FIFO mode
- `wr_en`  in  1  RAM write / FIFO push
- `rd_en`  in  1  RAM read / FIFO pop
- `wr_data`  in  DATA_W  write/push data
- `par_inj`  in  1  invert stored parity on this write; ignored when parity is compiled out
- `rd_data`  out  DATA_W  registered read data
- `rd_valid`  out  1  one-cycle pulse: `rd_data` updated this cycle
- `full`, `empty`  out  1  FIFO status
- `count`  out  ADDR_W+1  FIFO occupancy, 0..DEPTH
- `wr_err`  out  1  pulse: push rejected (FIFO full)
- `rd_err`  out  1  pulse: pop rejected (FIFO empty)
- `par_err`  out  1  pulse with `rd_valid` on parity mismatch; constant 0 without parity

## Operation
- Reset values:
  - `rd_data` = 0, `rd_valid` = 0
  - `wr_err` = 0, `rd_err` = 0, `par_err` = 0
  - `count` = 0, `empty` = 1, `full` = 0
  - Internal `mode_q` = 0, `wr_ptr` = 0, `rd_ptr` = 0
  - Storage array is not reset; its contents are undefined.
- `ena` = 0:
  - No state updates.
  - `rd_valid`, `wr_err`, `rd_err`, `par_err` are 0 on the next edge.
  - All other outputs hold.
- Mode switch, when `mode` ≠ `mode_q` at an enabled edge:
  - `mode_q` ← `mode`.
  - Pointers and `count` clear, giving `empty` = 1 and `full` = 0.
  - `wr_en` and `rd_en` are ignored that cycle; the array keeps its contents.
- RAM mode:
  - `wr_en` writes `mem[addr]` ← `wr_data`.
  - `rd_en` loads `rd_data` ← `mem[addr]` and pulses `rd_valid`.
  - Simultaneous read and write to the same address returns the old word (read-before-write); both operations complete.
  - FIFO status stays at its cleared values; `wr_err` and `rd_err` are never asserted.
- FIFO mode:
  - Push is accepted iff `!full`: `mem[wr_ptr]` ← `wr_data`, `wr_ptr`++ modulo DEPTH.
  - Pop is accepted iff `!empty`: `rd_data` ← `mem[rd_ptr]`, `rd_ptr`++ modulo DEPTH, `rd_valid` pulses.
  - Acceptance is judged on pre-edge status, so there is no full-pass-through or empty-bypass.
  - Push and pop together with 0 < `count` < DEPTH: both are accepted and `count` is unchanged.
  - Push and pop together when empty: push accepted, pop rejected (`rd_err`), `count` becomes 1.
  - Push and pop together when full: pop accepted, push rejected (`wr_err`), `count` becomes DEPTH−1.
  - `count` is a registered counter.
  - `full` = (`count` == DEPTH) and `empty` = (`count` == 0), both registered alongside `count`.
- A rejected operation leaves pointers, array and `rd_data` untouched.

## Timing
- Read latency is 1 cycle: with `rd_en` sampled at edge N, `rd_data`/`rd_valid` are valid after edge N and `rd_valid` drops after N+1 unless another read is accepted.
- Write latency: data written at edge N is readable by a read sampled at edge N+1.
- Status outputs (`count`, `full`, `empty`) update at the same edge as the push/pop.
- Error pulses are asserted for exactly the cycle following the rejected request.
- Asserting `rst_n` low mid-operation immediately forces all reset values, asynchronously; an in-flight `rd_valid` is lost.

## Configuration
- `DFF_MEM_PARITY_EN` defined:
  - Each word stores DATA_W+1 bits; the extra bit is even parity of `wr_data`, inverted when `par_inj` = 1.
  - Every accepted read checks the stored parity; `par_err` pulses alongside `rd_valid` on mismatch.
  - `rd_data` is still delivered unmodified.
- Not defined:
  - Array is DATA_W bits wide.
  - `par_inj` is unused; `par_err` is tied to 0.

## Test plan
- Reset, then idle: `rd_data` = 0, `empty` = 1, `count` = 0, `rd_valid` = 0; then `mode` = 0, write 0xA5 to addr 3, read addr 3 → `rd_data` = 0xA5 with `rd_valid` one cycle after `rd_en`.
- RAM mode, same-cycle write 0x5A and read at addr 3 (holding 0xA5) → `rd_data` = 0xA5; next read → 0x5A.
- FIFO mode, push 0x01..0x10 (16 words) → `full` = 1, `count` = 16; a 17th push → `wr_err` pulse, `count` stays 16; 16 pops return 0x01..0x10 in order, then `empty` = 1; a further pop → `rd_err`.
- FIFO with `count` = 5, push+pop together → `count` = 5, pop returns the oldest word; when empty, push+pop → `count` = 1 and `rd_err` pulses; when full, push+pop → `count` = 15 and `wr_err` pulses.
- FIFO with `count` = 3, toggle `mode` to 0 then back to 1 → `count` = 0, `empty` = 1, requests during the switch cycles are ignored; pull `rst_n` low mid-pop → outputs reset immediately.
- With `DFF_MEM_PARITY_EN`: write 0x3C with `par_inj` = 1, read it back → `rd_data` = 0x3C with `par_err` = 1; write with `par_inj` = 0 and read → `par_err` = 0.
